// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared pipeline-control definitions: hold-flag codes, the NOP encoding fetch
// substitutes while held, and the flush FSM state encoding.
package pipe_hold_ctrl_pkg;

   localparam logic [2:0] HOLD_NONE = 3'd0;
   localparam logic [2:0] HOLD_PC   = 3'd1;
   localparam logic [2:0] HOLD_IF   = 3'd2;
   localparam logic [2:0] HOLD_ID   = 3'd3;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } flushState_e;

endpackage

// File: rtl/pipe_hold_ctrl_stall_watchdog.sv
// Counts consecutive bus-stall cycles and raises a sticky timeout flag once the
// count reaches STALL_TIMEOUT; only reset clears the flag.
module pipe_hold_ctrl_stall_watchdog
   import pipe_hold_ctrl_pkg::*;
#(
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic hold_rib_i,
   output logic stall_timeout_o
);

   localparam int CntW = $clog2(STALL_TIMEOUT + 1);
   localparam logic [CntW-1:0] Limit = CntW'(STALL_TIMEOUT);
   localparam logic [CntW-1:0] One   = CntW'(1);

   logic [CntW-1:0] stallCnt_q, stallCnt_d;
   logic            timeout_q, timeout_d;

   // Saturating count of back-to-back stall cycles; a single ready cycle restarts it.
   always_comb begin
      stallCnt_d = '0;
      if (hold_rib_i) begin
         stallCnt_d = (stallCnt_q == Limit) ? stallCnt_q : stallCnt_q + One;
      end
      timeout_d = timeout_q | (stallCnt_d == Limit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         stallCnt_q <= stallCnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central hold/flush controller for the IF/ID pipeline registers: merges hold
// and redirect requests and stretches each redirect into a flush window.
module pipe_hold_ctrl
   import pipe_hold_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES  = 2,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold_ex_i,
   input  logic        hold_rib_i,
   input  logic        hold_clint_i,
   input  logic        jump_ex_i,
   input  logic [31:0] jump_addr_ex_i,
   input  logic        int_assert_i,
   input  logic [31:0] int_addr_i,
   output logic [2:0]  hold_flag_o,
   output logic        jump_flag_o,
   output logic [31:0] jump_addr_o,
   output logic        flush_busy_o,
   output logic        stall_timeout_o
);

   localparam logic [3:0] FlushReload = 4'(FLUSH_CYCLES - 1);

   flushState_e state_q, state_d;
   logic [3:0]  flushCnt_q, flushCnt_d;
   logic        redirect;

   // Interrupt redirects take priority over EX jumps.
   always_comb begin
      redirect    = int_assert_i | jump_ex_i;
      jump_flag_o = redirect;
      jump_addr_o = '0;
      if (int_assert_i) begin
         jump_addr_o = int_addr_i;
      end else if (jump_ex_i) begin
         jump_addr_o = jump_addr_ex_i;
      end
   end

   // A redirect in either state (re)starts the flush window.
   always_comb begin
      state_d    = state_q;
      flushCnt_d = flushCnt_q;
      unique case (state_q)
         IDLE: begin
            if (redirect) begin
               state_d    = FLUSH;
               flushCnt_d = FlushReload;
            end
         end
         FLUSH: begin
            if (redirect) begin
               flushCnt_d = FlushReload;
            end else if (flushCnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               flushCnt_d = flushCnt_q - 4'd1;
            end
         end
         default: begin
            state_d    = IDLE;
            flushCnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         flushCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   // Full-pipe holds outrank a bus stall, so a redirect during a stall still flushes.
   always_comb begin
      flush_busy_o = (state_q == FLUSH);
      hold_flag_o  = HOLD_NONE;
      if (redirect || flush_busy_o || hold_clint_i || hold_ex_i) begin
         hold_flag_o = HOLD_ID;
      end else if (hold_rib_i) begin
         hold_flag_o = HOLD_PC;
      end
   end

   pipe_hold_ctrl_stall_watchdog #(
      .STALL_TIMEOUT (STALL_TIMEOUT)
   ) uStallWatchdog (
      .clk             (clk),
      .rst_n           (rst_n),
      .hold_rib_i      (hold_rib_i),
      .stall_timeout_o (stall_timeout_o)
   );

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl: a cycle-by-cycle vector table plus
// hand-written sequences for the stall watchdog and asynchronous reset mid-flush.
module tb_pipe_hold_ctrl;

   typedef struct {
      logic        holdEx;
      logic        holdRib;
      logic        holdClint;
      logic        jumpEx;
      logic [31:0] jumpAddr;
      logic        intAssert;
      logic [31:0] intAddr;
      logic [2:0]  expHold;
      logic        expJump;
      logic [31:0] expAddr;
      logic        expBusy;
   } vector_t;

   localparam int NumVec = 21;

   logic        clk;
   logic        rst_n;
   logic        hold_ex_i;
   logic        hold_rib_i;
   logic        hold_clint_i;
   logic        jump_ex_i;
   logic [31:0] jump_addr_ex_i;
   logic        int_assert_i;
   logic [31:0] int_addr_i;
   logic [2:0]  hold_flag_o;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic        flush_busy_o;
   logic        stall_timeout_o;

   int checks;
   int errors;
   vector_t vecs [NumVec];

   pipe_hold_ctrl #(
      .FLUSH_CYCLES  (2),
      .STALL_TIMEOUT (1024)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .hold_ex_i       (hold_ex_i),
      .hold_rib_i      (hold_rib_i),
      .hold_clint_i    (hold_clint_i),
      .jump_ex_i       (jump_ex_i),
      .jump_addr_ex_i  (jump_addr_ex_i),
      .int_assert_i    (int_assert_i),
      .int_addr_i      (int_addr_i),
      .hold_flag_o     (hold_flag_o),
      .jump_flag_o     (jump_flag_o),
      .jump_addr_o     (jump_addr_o),
      .flush_busy_o    (flush_busy_o),
      .stall_timeout_o (stall_timeout_o)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one vector's inputs onto the DUT.
   task automatic applyStimulus(input vector_t v);
      hold_ex_i      = v.holdEx;
      hold_rib_i     = v.holdRib;
      hold_clint_i   = v.holdClint;
      jump_ex_i      = v.jumpEx;
      jump_addr_ex_i = v.jumpAddr;
      int_assert_i   = v.intAssert;
      int_addr_i     = v.intAddr;
   endtask

   // Compares one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Quick-build helper for table rows.
   function automatic vector_t mkVec(logic ex, logic rib, logic clint, logic jmp,
                                     logic [31:0] jAddr, logic irq, logic [31:0] iAddr,
                                     logic [2:0] eHold, logic eJump, logic [31:0] eAddr,
                                     logic eBusy);
      vector_t v;
      v.holdEx    = ex;
      v.holdRib   = rib;
      v.holdClint = clint;
      v.jumpEx    = jmp;
      v.jumpAddr  = jAddr;
      v.intAssert = irq;
      v.intAddr   = iAddr;
      v.expHold   = eHold;
      v.expJump   = eJump;
      v.expAddr   = eAddr;
      v.expBusy   = eBusy;
      return v;
   endfunction

   // Main test sequence.
   initial begin
      vector_t idleVec;
      checks = 0;
      errors = 0;

      // Consecutive cycles; expectations carry the flush window across rows (FLUSH_CYCLES=2).
      vecs[0]  = mkVec(0,0,0,0,32'hBEEF,0,32'hDEAD, 3'd0,0,32'h0,  0);
      vecs[1]  = mkVec(1,0,0,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  0);
      vecs[2]  = mkVec(0,0,1,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  0);
      vecs[3]  = mkVec(0,1,0,0,32'h0,   0,32'h0,    3'd1,0,32'h0,  0);
      vecs[4]  = mkVec(1,1,0,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  0);
      vecs[5]  = mkVec(0,0,0,1,32'h100, 0,32'h0,    3'd3,1,32'h100,0);
      vecs[6]  = mkVec(0,0,0,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  1);
      vecs[7]  = mkVec(0,0,0,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  1);
      vecs[8]  = mkVec(0,0,0,0,32'h0,   0,32'h0,    3'd0,0,32'h0,  0);
      vecs[9]  = mkVec(0,0,0,1,32'h200, 1,32'h8,    3'd3,1,32'h8,  0);
      vecs[10] = mkVec(0,0,0,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  1);
      vecs[11] = mkVec(0,0,0,1,32'h300, 0,32'h0,    3'd3,1,32'h300,1);
      vecs[12] = mkVec(0,0,0,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  1);
      vecs[13] = mkVec(0,0,0,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  1);
      vecs[14] = mkVec(0,0,0,0,32'h0,   0,32'h0,    3'd0,0,32'h0,  0);
      vecs[15] = mkVec(0,1,0,0,32'h0,   1,32'h40,   3'd3,1,32'h40, 0);
      vecs[16] = mkVec(0,1,0,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  1);
      vecs[17] = mkVec(0,1,0,0,32'h0,   0,32'h0,    3'd3,0,32'h0,  1);
      vecs[18] = mkVec(0,1,0,0,32'h0,   0,32'h0,    3'd1,0,32'h0,  0);
      vecs[19] = mkVec(0,0,0,0,32'h0,   0,32'h0,    3'd0,0,32'h0,  0);
      vecs[20] = mkVec(0,0,0,0,32'h0,   1,32'hC0,   3'd3,1,32'hC0, 0);

      idleVec = mkVec(0,0,0,0,32'h0,0,32'h0, 3'd0,0,32'h0,0);
      applyStimulus(idleVec);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset hold_flag", 32'(hold_flag_o), 32'd0);
      checkOutput("reset timeout", 32'(stall_timeout_o), 32'd0);
      rst_n = 1'b1;

      $display("[TB] idle after reset release");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         checkOutput($sformatf("idle%0d hold_flag", i), 32'(hold_flag_o), 32'd0);
         checkOutput($sformatf("idle%0d jump_flag", i), 32'(jump_flag_o), 32'd0);
         checkOutput($sformatf("idle%0d flush_busy", i), 32'(flush_busy_o), 32'd0);
      end

      $display("[TB] vector table");
      for (int i = 0; i < NumVec; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d hold_flag", i), 32'(hold_flag_o), 32'(vecs[i].expHold));
         checkOutput($sformatf("vec%0d jump_flag", i), 32'(jump_flag_o), 32'(vecs[i].expJump));
         checkOutput($sformatf("vec%0d jump_addr", i), jump_addr_o, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d flush_busy", i), 32'(flush_busy_o), 32'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d timeout", i), 32'(stall_timeout_o), 32'd0);
      end

      // Let the final redirect's flush window drain before the watchdog run.
      @(negedge clk);
      applyStimulus(idleVec);
      repeat (3) @(negedge clk);
      checkOutput("drain flush_busy", 32'(flush_busy_o), 32'd0);

      $display("[TB] stall watchdog");
      idleVec.holdRib = 1'b1;
      applyStimulus(idleVec);
      for (int i = 1; i <= 1024; i++) begin
         #1;
         checkOutput($sformatf("rib%0d hold_flag", i), 32'(hold_flag_o), 32'd1);
         @(negedge clk);
         if (i == 1023) begin
            checkOutput("timeout before limit", 32'(stall_timeout_o), 32'd0);
         end
      end
      checkOutput("timeout at limit", 32'(stall_timeout_o), 32'd1);
      idleVec.holdRib = 1'b0;
      applyStimulus(idleVec);
      repeat (4) @(negedge clk);
      checkOutput("timeout sticky", 32'(stall_timeout_o), 32'd1);
      checkOutput("after rib hold_flag", 32'(hold_flag_o), 32'd0);

      $display("[TB] async reset mid-flush");
      idleVec.jumpEx   = 1'b1;
      idleVec.jumpAddr = 32'h400;
      applyStimulus(idleVec);
      @(negedge clk);
      idleVec.jumpEx   = 1'b0;
      idleVec.jumpAddr = 32'h0;
      applyStimulus(idleVec);
      #1;
      checkOutput("preflush busy", 32'(flush_busy_o), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst flush_busy", 32'(flush_busy_o), 32'd0);
      checkOutput("rst hold_flag", 32'(hold_flag_o), 32'd0);
      checkOutput("rst timeout", 32'(stall_timeout_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("post-rst flush_busy", 32'(flush_busy_o), 32'd0);
      checkOutput("post-rst hold_flag", 32'(hold_flag_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
